serial_chunk_adder: RTL

Multi-cycle WIDTH-bit adder that adds CHUNK bits per clock through a CHUNK-wide full-adder ripple chain, carrying between beats in a register. It is the parametrised, sequential successor to the single-bit full adder: it trades latency for area in wide datapaths. It sits behind a start/busy/done handshake so a controller can issue one operation at a time.

---
 rtl/serial_chunk_adder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_chunk_adder.sv
// -----------------------------------------------------------------------------
// serial_chunk_adder
//
// Multi-cycle WIDTH-bit adder. Each RUN beat adds one CHUNK-bit slice of the
// captured operands through a CHUNK-wide ripple chain. The carry between beats
// is held in a register. A start/busy/done handshake lets a controller issue
// one operation at a time. Latency is BEATS+1 edges from the accepted start to
// the done pulse, where BEATS = WIDTH/CHUNK.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' port. With
// sub=1 at capture, B is inverted and the initial carry is forced to 1, so the
// result is A - B. In that case carry=1 means no borrow.
//
// Parameters:
//   WIDTH     operand/result width; must be a positive multiple of CHUNK
//   CHUNK     bits added per beat (1..WIDTH)
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request; sampled only in IDLE or DONE
//   A, B      operands, captured when start is accepted
//   cin       carry-in, captured when start is accepted
//   sub       subtract select (SERIAL_ADDER_SUB_EN only)
//   busy      high while the operation is in progress
//   done      one-cycle pulse; sum/carry/overflow are valid
//   sum       result register (partial while busy)
//   carry     carry out of bit WIDTH-1
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int BEATS = WIDTH / CHUNK;
  localparam int IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx;

  logic [WIDTH-1:0] b_capt;
  logic             cin_capt;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_out;
  logic             c_into_msb;
  logic             last_beat;
  logic             accept;

  // Operand conditioning at capture time.
`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtraction: A + ~B + 1. cin is ignored when sub=1.
  assign b_capt   = sub ? ~B : B;
  assign cin_capt = sub | cin;
`else
  assign b_capt   = B;
  assign cin_capt = cin;
`endif

  // The operand registers shift down one chunk per beat. The active slice is
  // always at the bottom, so no variable part-select is needed on the read side.
  assign a_chunk = a_reg[CHUNK-1:0];
  assign b_chunk = b_reg[CHUNK-1:0];

  assign {c_out, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                          + {{CHUNK{1'b0}}, carry_reg};

  // Carry into the top bit of this chunk, recovered from the sum bit:
  // s = a ^ b ^ c_in, so c_in = a ^ b ^ s. This is only meaningful on the
  // final beat, where that bit is the result MSB.
  assign c_into_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];

  assign last_beat = (idx == LAST_IDX);
  assign accept    = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Next-state logic.
  always_comb begin
    // NOTE: assign a default before the case so that no path leaves state_nxt
    // unassigned. An unassigned path would infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers.
  // NOTE: every register here is a small flop with an async reset. All state
  // updates use non-blocking assignments, so every read in this block sees the
  // value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= b_capt;
      carry_reg <= cin_capt;
      idx       <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == RUN) begin
      a_reg     <= a_reg >> CHUNK;
      b_reg     <= b_reg >> CHUNK;
      carry_reg <= c_out;
      idx       <= idx + 1'b1;
      // Place the chunk result at its final bit position so that sum reads
      // as a partially filled result while busy.
      for (int k = 0; k < BEATS; k++) begin
        if (idx == IDXW'(k)) sum[k*CHUNK +: CHUNK] <= s_chunk;
      end
      if (last_beat) begin
        carry    <= c_out;
        overflow <= c_into_msb ^ c_out;
      end
    end
  end

endmodule
